// File: rtl/iccm_port_arbiter.sv
// Arbitrates one single-port DFFRAM between the core instruction port and the UART
// program loader. It generates the grants, the RAM strobes and the one-cycle read response.
module iccm_port_arbiter #(
  parameter int AW           = 14,
  parameter int RAM_AW       = 8,
  parameter int MAX_LD_BURST = 4
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              boot_done_i,
  // Both ports use req/gnt. A transfer happens in the cycle where req and gnt are
  // both high. gnt is combinational from req. A requester holds its request until it is granted.
  input  logic              core_req_i,
  output logic              core_gnt_o,
  input  logic              core_we_i,
  input  logic [AW-1:0]     core_addr_i,
  input  logic [31:0]       core_wdata_i,
  input  logic [31:0]       core_wmask_i,
  output logic [31:0]       core_rdata_o,
  output logic              core_rvalid_o,
  output logic [1:0]        core_rerror_o,
  input  logic              ld_req_i,
  output logic              ld_gnt_o,
  input  logic [AW-1:0]     ld_addr_i,
  input  logic [31:0]       ld_wdata_i,
  output logic              ram_en_o,
  output logic [3:0]        ram_we_o,
  output logic [RAM_AW-1:0] ram_a_o,
  output logic [31:0]       ram_di_o,
  input  logic [31:0]       ram_do_i,
  output logic [7:0]        err_cnt_o
);

  localparam logic [3:0] BURST_MAX = 4'(MAX_LD_BURST);

  logic [3:0] burst_q, burst_d;
  logic [7:0] err_cnt_q, err_cnt_d;
  logic       rvalid_q, rvalid_d;
  logic [1:0] rerror_q, rerror_d;

  logic       core_oor, ld_oor;
  logic       burst_full;
  logic       core_gnt, ld_gnt;
  logic       err_inc;
  logic [3:0] core_byte_we;

  always_comb begin
    core_oor   = |core_addr_i[AW-1:RAM_AW];
    ld_oor     = |ld_addr_i[AW-1:RAM_AW];
    // The loader normally wins in RUN mode. After MAX_LD_BURST back-to-back loader
    // wins while the core waits, the core gets one turn.
    burst_full = boot_done_i && core_req_i && (burst_q == BURST_MAX);
    ld_gnt     = rst_ni && ld_req_i && !burst_full;
    core_gnt   = rst_ni && boot_done_i && core_req_i && (!ld_req_i || burst_full);
    for (int i = 0; i < 4; i++) begin
      core_byte_we[i] = core_we_i && (|core_wmask_i[8*i +: 8]);
    end
  end

  always_comb begin
    ram_en_o = 1'b0;
    ram_we_o = 4'h0;
    ram_a_o  = core_addr_i[RAM_AW-1:0];
    ram_di_o = core_wdata_i;
    if (ld_gnt) begin
      ram_a_o  = ld_addr_i[RAM_AW-1:0];
      ram_di_o = ld_wdata_i;
      if (!ld_oor) begin
        ram_en_o = 1'b1;
        ram_we_o = 4'hF;
      end
    end else if (core_gnt && !core_oor) begin
      ram_en_o = 1'b1;
      ram_we_o = core_byte_we;
    end
  end

  always_comb begin
    burst_d = burst_q;
    if (!boot_done_i || !core_req_i || core_gnt) begin
      burst_d = 4'd0;
    end else if (ld_gnt && (burst_q != BURST_MAX)) begin
      burst_d = burst_q + 4'd1;
    end

    err_inc   = (ld_gnt && ld_oor) || (core_gnt && core_oor);
    err_cnt_d = err_cnt_q;
    if (err_inc && (err_cnt_q != 8'hFF)) begin
      err_cnt_d = err_cnt_q + 8'd1;
    end

    // Only granted core reads produce a response. Writes with any mask, including all-zero, produce none.
    rvalid_d = core_gnt && !core_we_i;
    rerror_d = (core_gnt && !core_we_i && core_oor) ? 2'b01 : 2'b00;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      burst_q   <= 4'd0;
      err_cnt_q <= 8'd0;
      rvalid_q  <= 1'b0;
      rerror_q  <= 2'b00;
    end else begin
      burst_q   <= burst_d;
      err_cnt_q <= err_cnt_d;
      rvalid_q  <= rvalid_d;
      rerror_q  <= rerror_d;
    end
  end

  assign core_gnt_o    = core_gnt;
  assign ld_gnt_o      = ld_gnt;
  assign core_rvalid_o = rvalid_q;
  assign core_rerror_o = rerror_q;
  // RAM Do holds its value until the next enabled read. A loader write in the response cycle therefore cannot disturb it.
  assign core_rdata_o  = (rvalid_q && (rerror_q == 2'b00)) ? ram_do_i : 32'h0;
  assign err_cnt_o     = err_cnt_q;

endmodule

// File: tb/tb_iccm_port_arbiter.sv
// Directed bench for iccm_port_arbiter: a vector table plus hand-written sequences
// for counter saturation and for reset during a read. A behavioural DFFRAM model sits behind the arbiter.
module tb_iccm_port_arbiter;

  logic        clk;
  logic        rst_ni;
  logic        boot_done_i;
  logic        core_req_i;
  logic        core_gnt_o;
  logic        core_we_i;
  logic [13:0] core_addr_i;
  logic [31:0] core_wdata_i;
  logic [31:0] core_wmask_i;
  logic [31:0] core_rdata_o;
  logic        core_rvalid_o;
  logic [1:0]  core_rerror_o;
  logic        ld_req_i;
  logic        ld_gnt_o;
  logic [13:0] ld_addr_i;
  logic [31:0] ld_wdata_i;
  logic        ram_en_o;
  logic [3:0]  ram_we_o;
  logic [7:0]  ram_a_o;
  logic [31:0] ram_di_o;
  logic [31:0] ram_do_i;
  logic [7:0]  err_cnt_o;

  int n_checks = 0;
  int n_fail   = 0;

  iccm_port_arbiter #(.AW(14), .RAM_AW(8), .MAX_LD_BURST(4)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .boot_done_i(boot_done_i),
    .core_req_i(core_req_i), .core_gnt_o(core_gnt_o), .core_we_i(core_we_i),
    .core_addr_i(core_addr_i), .core_wdata_i(core_wdata_i), .core_wmask_i(core_wmask_i),
    .core_rdata_o(core_rdata_o), .core_rvalid_o(core_rvalid_o), .core_rerror_o(core_rerror_o),
    .ld_req_i(ld_req_i), .ld_gnt_o(ld_gnt_o), .ld_addr_i(ld_addr_i), .ld_wdata_i(ld_wdata_i),
    .ram_en_o(ram_en_o), .ram_we_o(ram_we_o), .ram_a_o(ram_a_o), .ram_di_o(ram_di_o),
    .ram_do_i(ram_do_i), .err_cnt_o(err_cnt_o)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // DFFRAM model: byte writes; Do updates only on an enabled read
  logic [31:0] mem [0:255];
  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    ram_do_i = 32'h0;
  end
  always @(posedge clk) begin
    if (ram_en_o) begin
      for (int b = 0; b < 4; b++) begin
        if (ram_we_o[b]) mem[ram_a_o][8*b +: 8] <= ram_di_o[8*b +: 8];
      end
      if (ram_we_o == 4'h0) ram_do_i <= mem[ram_a_o];
    end
  end

  typedef struct {
    logic        boot, creq, cwe;
    logic [13:0] caddr;
    logic [31:0] cwdata, cmask;
    logic        lreq;
    logic [13:0] laddr;
    logic [31:0] lwdata;
    logic        cgnt, lgnt, en;
    logic [3:0]  we;
    logic [7:0]  a;
    logic        rvalid;
    logic [1:0]  rerr;
    logic [31:0] rdata;
    logic [7:0]  errc;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(
    input logic [31:0] boot, creq, cwe, caddr, cwdata, cmask,
    input logic [31:0] lreq, laddr, lwdata,
    input logic [31:0] cgnt, lgnt, en, we, a,
    input logic [31:0] rvalid, rerr, rdata, errc);
    vec_t v;
    v.boot = boot[0];  v.creq = creq[0];  v.cwe = cwe[0];
    v.caddr = caddr[13:0];  v.cwdata = cwdata;  v.cmask = cmask;
    v.lreq = lreq[0];  v.laddr = laddr[13:0];  v.lwdata = lwdata;
    v.cgnt = cgnt[0];  v.lgnt = lgnt[0];  v.en = en[0];
    v.we = we[3:0];  v.a = a[7:0];
    v.rvalid = rvalid[0];  v.rerr = rerr[1:0];  v.rdata = rdata;  v.errc = errc[7:0];
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // driver tasks
  task automatic drive(input logic boot, creq, cwe, input logic [13:0] caddr,
                       input logic [31:0] cwdata, cmask, input logic lreq,
                       input logic [13:0] laddr, input logic [31:0] lwdata);
    boot_done_i = boot;  core_req_i = creq;  core_we_i = cwe;
    core_addr_i = caddr; core_wdata_i = cwdata; core_wmask_i = cmask;
    ld_req_i = lreq;     ld_addr_i = laddr;   ld_wdata_i = lwdata;
  endtask

  task automatic idle(input logic boot);
    drive(boot, 1'b0, 1'b0, 14'h0, 32'h0, 32'h0, 1'b0, 14'h0, 32'h0);
  endtask

  initial begin
    // Reset with both requesters active: grants forced low, registers cleared.
    rst_ni = 1'b0;
    drive(1'b1, 1'b1, 1'b0, 14'h005, 32'h0, 32'h0, 1'b1, 14'h005, 32'h0);
    @(negedge clk); #1;
    check("rst_core_gnt", core_gnt_o, 0);
    check("rst_ld_gnt", ld_gnt_o, 0);
    check("rst_rvalid", core_rvalid_o, 0);
    check("rst_rerror", core_rerror_o, 0);
    check("rst_err_cnt", err_cnt_o, 0);
    idle(1'b0);
    @(negedge clk);
    rst_ni = 1'b1;

    //             boot creq cwe caddr  cwdata        cmask         lreq laddr   lwdata         cgnt lgnt en we      a       rv rerr rdata         errc
    vecs.push_back(mk(0, 1, 0, 'h005, 0,            0,            1, 'h005,  'hDEADBEEF,    0, 1, 1, 'hF,    'h05,   0, 0, 0,            0));
    vecs.push_back(mk(0, 1, 0, 'h005, 0,            0,            0, 0,      0,             0, 0, 0, 0,      'h05,   0, 0, 0,            0));
    vecs.push_back(mk(1, 1, 0, 'h005, 0,            0,            0, 0,      0,             1, 0, 1, 0,      'h05,   0, 0, 0,            0));
    vecs.push_back(mk(1, 0, 0, 0,     0,            0,            0, 0,      0,             0, 0, 0, 0,      'h00,   1, 0, 'hDEADBEEF,   0));
    vecs.push_back(mk(1, 1, 1, 'h005, 'h11223344,   'h0000FF00,   0, 0,      0,             1, 0, 1, 'b0010, 'h05,   0, 0, 0,            0));
    vecs.push_back(mk(1, 1, 0, 'h005, 0,            0,            0, 0,      0,             1, 0, 1, 0,      'h05,   0, 0, 0,            0));
    vecs.push_back(mk(1, 0, 0, 0,     0,            0,            0, 0,      0,             0, 0, 0, 0,      'h00,   1, 0, 'hDEAD33EF,   0));
    vecs.push_back(mk(1, 1, 1, 'h005, 'hFFFFFFFF,   0,            0, 0,      0,             1, 0, 1, 0,      'h05,   0, 0, 0,            0));
    vecs.push_back(mk(1, 1, 0, 'h005, 0,            0,            0, 0,      0,             1, 0, 1, 0,      'h05,   0, 0, 0,            0));
    vecs.push_back(mk(1, 0, 0, 0,     0,            0,            0, 0,      0,             0, 0, 0, 0,      'h00,   1, 0, 'hDEAD33EF,   0));
    // Contention: L,L,L,L,C twice
    for (int k = 0; k < 4; k++)
      vecs.push_back(mk(1, 1, 0, 'h010, 0, 0, 1, 'h010 + k, 'h10000010 + k, 0, 1, 1, 'hF, 'h10 + k, 0, 0, 0, 0));
    vecs.push_back(mk(1, 1, 0, 'h010, 0,            0,            1, 'h030,  'hBADBAD00,    1, 0, 1, 0,      'h10,   0, 0, 0,            0));
    vecs.push_back(mk(1, 1, 0, 'h010, 0,            0,            1, 'h014,  'h10000014,    0, 1, 1, 'hF,    'h14,   1, 0, 'h10000010,   0));
    for (int k = 1; k < 4; k++)
      vecs.push_back(mk(1, 1, 0, 'h010, 0, 0, 1, 'h014 + k, 'h10000014 + k, 0, 1, 1, 'hF, 'h14 + k, 0, 0, 0, 0));
    vecs.push_back(mk(1, 1, 0, 'h010, 0,            0,            1, 'h030,  'hBADBAD00,    1, 0, 1, 0,      'h10,   0, 0, 0,            0));
    // core_req drop in the middle of a burst clears the count
    vecs.push_back(mk(1, 1, 0, 'h010, 0,            0,            1, 'h020,  'h20,          0, 1, 1, 'hF,    'h20,   1, 0, 'h10000010,   0));
    vecs.push_back(mk(1, 0, 0, 'h010, 0,            0,            1, 'h021,  'h21,          0, 1, 1, 'hF,    'h21,   0, 0, 0,            0));
    for (int k = 2; k < 6; k++)
      vecs.push_back(mk(1, 1, 0, 'h010, 0, 0, 1, 'h020 + k, 'h20 + k, 0, 1, 1, 'hF, 'h20 + k, 0, 0, 0, 0));
    vecs.push_back(mk(1, 1, 0, 'h010, 0,            0,            1, 'h026,  'h26,          1, 0, 1, 0,      'h10,   0, 0, 0,            0));
    vecs.push_back(mk(1, 0, 0, 0,     0,            0,            0, 0,      0,             0, 0, 0, 0,      'h00,   1, 0, 'h10000010,   0));
    // Out-of-range accesses from both ports
    vecs.push_back(mk(1, 1, 0, 'h100, 0,            0,            0, 0,      0,             1, 0, 0, 0,      'h00,   0, 0, 0,            0));
    vecs.push_back(mk(1, 0, 0, 0,     0,            0,            0, 0,      0,             0, 0, 0, 0,      'h00,   1, 1, 0,            1));
    vecs.push_back(mk(1, 0, 0, 0,     0,            0,            1, 'h3F00, 'h77,          0, 1, 0, 0,      'h00,   0, 0, 0,            1));
    vecs.push_back(mk(1, 1, 1, 'h200, 'h55,         'hFFFFFFFF,   0, 0,      0,             1, 0, 0, 0,      'h00,   0, 0, 0,            2));
    vecs.push_back(mk(1, 0, 0, 0,     0,            0,            0, 0,      0,             0, 0, 0, 0,      'h00,   0, 0, 0,            3));

    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i].boot, vecs[i].creq, vecs[i].cwe, vecs[i].caddr, vecs[i].cwdata,
            vecs[i].cmask, vecs[i].lreq, vecs[i].laddr, vecs[i].lwdata);
      #1;
      check($sformatf("v%0d core_gnt", i), core_gnt_o, vecs[i].cgnt);
      check($sformatf("v%0d ld_gnt", i), ld_gnt_o, vecs[i].lgnt);
      check($sformatf("v%0d ram_en", i), ram_en_o, vecs[i].en);
      check($sformatf("v%0d ram_we", i), ram_we_o, vecs[i].we);
      check($sformatf("v%0d ram_a", i), ram_a_o, vecs[i].a);
      check($sformatf("v%0d rvalid", i), core_rvalid_o, vecs[i].rvalid);
      check($sformatf("v%0d rerror", i), core_rerror_o, vecs[i].rerr);
      check($sformatf("v%0d rdata", i), core_rdata_o, vecs[i].rdata);
      check($sformatf("v%0d err_cnt", i), err_cnt_o, vecs[i].errc);
    end

    // err_cnt saturation: 3 errors so far, plus 300 out-of-range reads
    for (int n = 1; n <= 300; n++) begin
      @(negedge clk);
      drive(1'b1, 1'b1, 1'b0, 14'h100, 32'h0, 32'h0, 1'b0, 14'h0, 32'h0);
      if (n == 101) begin
        #1;
        check("err_cnt_mid", err_cnt_o, 103);
      end
    end
    @(negedge clk);
    idle(1'b1);
    #1;
    check("sat_err_cnt", err_cnt_o, 255);
    check("sat_rvalid", core_rvalid_o, 1);
    check("sat_rerror", core_rerror_o, 2'b01);
    check("sat_rdata", core_rdata_o, 0);

    // Reset pulsed while a core read is being granted
    @(negedge clk);
    drive(1'b1, 1'b1, 1'b0, 14'h005, 32'h0, 32'h0, 1'b0, 14'h0, 32'h0);
    #1;
    check("mid_rst_gnt_before", core_gnt_o, 1);
    #2;
    rst_ni = 1'b0;
    #1;
    check("mid_rst_gnt_forced", core_gnt_o, 0);
    check("mid_rst_err_cnt", err_cnt_o, 0);
    @(negedge clk);
    check("mid_rst_rvalid_in_rst", core_rvalid_o, 0);
    idle(1'b1);
    rst_ni = 1'b1;
    @(negedge clk); #1;
    check("mid_rst_rvalid_after", core_rvalid_o, 0);
    check("mid_rst_err_after", err_cnt_o, 0);

    // Normal operation resumes after reset
    @(negedge clk);
    drive(1'b1, 1'b1, 1'b0, 14'h005, 32'h0, 32'h0, 1'b0, 14'h0, 32'h0);
    @(negedge clk);
    idle(1'b1);
    #1;
    check("post_rst_rvalid", core_rvalid_o, 1);
    check("post_rst_rdata", core_rdata_o, 32'hDEAD33EF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/iccm_port_arbiter.md
Name: iccm_port_arbiter

Overview:
- Shares one single-port 32-bit DFFRAM instruction memory between two requesters: the core instruction port (read/write, byte-masked) and the UART program loader (word writes only).
- Produces the grant, `rvalid` and `rerror` responses the core expects.
- Drives the RAM enable, per-byte write enables, address and write data.
- Sits between the core top, the ICCM loader and the DFFRAM macro, replacing ad-hoc muxing on reset state.

Parameters:
- AW, 14, core/loader word-address width.
- RAM_AW, 8, implemented RAM word-address width (depth 2^RAM_AW).
- MAX_LD_BURST, 4, consecutive loader grants allowed while core waits (RUN mode only); range 1..15.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  async active-low reset.
- boot_done_i  in  1  level; 0 = BOOT mode, 1 = RUN mode.
- core_req_i  in  1  core request.
- core_gnt_o  out  1  core granted this cycle.
- core_we_i  in  1  core write.
- core_addr_i  in  AW  core word address.
- core_wdata_i  in  32  core write data.
- core_wmask_i  in  32  core bit mask.
- core_rdata_o  out  32  read data.
- core_rvalid_o  out  1  read response valid.
- core_rerror_o  out  2  read error.
- ld_req_i  in  1  loader write request.
- ld_gnt_o  out  1  loader granted.
- ld_addr_i  in  AW  loader word address.
- ld_wdata_i  in  32  loader data.
- ram_en_o  out  1  RAM enable.
- ram_we_o  out  4  RAM byte write enables.
- ram_a_o  out  RAM_AW  RAM address.
- ram_di_o  out  32  RAM write data.
- ram_do_i  in  32  RAM read data (valid 1 cycle after enabled read).
- err_cnt_o  out  8  saturating out-of-range access count.

Behaviour:
- Reset (async, `rst_ni`=0): `core_rvalid_o`=0, `core_rerror_o`=0, `err_cnt_o`=0, burst counter=0, pending-read flag=0.
  - Combinational outputs follow the request inputs; `core_gnt_o`/`ld_gnt_o` are forced 0 while `rst_ni`=0.
- Grants are combinational, same cycle as the request; at most one grant per cycle.
- BOOT mode (`boot_done_i`=0):
  - `ld_gnt_o` = `ld_req_i`.
  - `core_gnt_o` = 0.
  - Core requests wait.
- RUN mode (`boot_done_i`=1):
  - Loader has priority over the core, except when burst count = MAX_LD_BURST and `core_req_i`=1; then the core is granted and the count clears.
  - Burst count increments on each loader grant while `core_req_i`=1.
  - Burst count clears on any core grant, or when `core_req_i`=0.
- `boot_done_i` may toggle at any time; mode is evaluated every cycle. There is no in-flight loader transaction to abort (single-cycle writes).
- Loader grant:
  - `ram_en_o`=1, `ram_we_o`=4'hF.
  - `ram_a_o`=`ld_addr_i[RAM_AW-1:0]`, `ram_di_o`=`ld_wdata_i`.
- Core grant:
  - `ram_a_o`=`core_addr_i[RAM_AW-1:0]`, `ram_di_o`=`core_wdata_i`.
  - `ram_we_o[i]` = `core_we_i` & |`core_wmask_i[8i+7:8i]`.
  - `ram_en_o`=1.
  - A write with an all-zero mask is granted with no byte written and no response.
- No grant: `ram_en_o`=0, `ram_we_o`=0. Address and data outputs are don't-care but held to the core inputs.
- Out of range: any `addr[AW-1:RAM_AW]` != 0.
  - Granted normally, but `ram_en_o`=0 and `ram_we_o`=0.
  - `err_cnt_o` increments, saturating at 255.
  - Loader and core errors are both counted.
- Read response, latency 1:
  - In-range granted core read at cycle N → `core_rvalid_o`=1 at N+1, `core_rdata_o`=`ram_do_i`, `core_rerror_o`=2'b00.
  - Out-of-range read → `core_rvalid_o`=1 at N+1, `core_rerror_o`=2'b01, `core_rdata_o`=32'h0.
  - Core writes never produce `core_rvalid_o`.
- `core_rvalid_o` is registered and pulses one cycle per granted read, so back-to-back reads give back-to-back rvalids.
- A loader grant in cycle N+1 does not corrupt the response for a core read granted in N. `ram_do_i` is sampled combinationally in N+1 and RAM Do holds until the next enabled read.
- Reset asserted mid-read drops the pending rvalid; no response is issued after reset release.

Test Plan:
- Reset, then `boot_done_i`=0 with core read and loader write both requesting → `ld_gnt_o`=1, `core_gnt_o`=0, `ram_we_o`=4'hF; core stays ungranted until `boot_done_i`=1.
- RUN mode, loader writes 32'hDEADBEEF to address 0x05, then core reads 0x05 → `core_gnt_o`=1, next cycle `core_rvalid_o`=1 with `core_rdata_o`=32'hDEADBEEF and `core_rerror_o`=0.
- Core write with `core_wmask_i`=32'h0000FF00 and data 32'h11223344 → `ram_we_o`=4'b0010, no rvalid. A readback returns only byte 1 changed (0x33).
- Loader and core both requesting continuously in RUN, MAX_LD_BURST=4 → grant pattern L,L,L,L,C repeating; burst count resets after each C.
- Core read at address 0x100 (RAM_AW=8) → `ram_en_o`=0, next cycle `core_rvalid_o`=1 with `core_rerror_o`=2'b01 and data 0. `err_cnt_o` increments; after 300 such reads `err_cnt_o`=255.
- Core read granted, `rst_ni` pulsed low in the same cycle → `core_rvalid_o` stays 0 and `err_cnt_o`=0 after release.
